// File: rtl/instr_pkg.sv
// Shared instruction-set definitions for the sequencer and the processor
// control unit: opcodes, the NOP word, per-opcode cycle counts and the
// sequencer state encoding.
package instr_pkg;

  localparam logic [3:0]  OP_LOAD  = 4'b0000;
  localparam logic [3:0]  OP_MOV   = 4'b0001;
  localparam logic [3:0]  OP_ADD   = 4'b0101;
  localparam logic [3:0]  OP_XOR   = 4'b0111;
  localparam logic [3:0]  OP_NOP   = 4'b1111;

  localparam logic [15:0] NOP_WORD = 16'hF000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  // Number of clocks the control unit spends on one word of this opcode.
  // Each LOAD word is a single-cycle word; the pair is handled by the sequencer.
  function automatic logic [1:0] cycles_for(input logic [3:0] opcode);
    case (opcode)
      OP_ADD, OP_XOR:         return 2'd3;
      OP_LOAD, OP_MOV, OP_NOP: return 2'd1;
      default:                return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: 2**ADDR_W x 16, synchronous write, combinational read.
// Contents are deliberately not reset.
module prog_ram #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [15:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];

  // Write port: store the word on the strobe edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps a PC through the program RAM and holds each
// word on instr for as many clocks as the control unit needs for its opcode.
// Optional build macro INSTR_SEQ_PERF_EN adds instr_count / cycle_count.
module instr_sequencer #(
  parameter int          ADDR_W   = 4,
  parameter logic [15:0] NOP_WORD = instr_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_wdata,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              halt_req,
  output logic [15:0]       instr,
  output logic [1:0]        step,
  output logic [ADDR_W:0]   pc,
  output logic              running,
  output logic              done
`ifdef INSTR_SEQ_PERF_EN
  ,
  output logic [15:0]       instr_count,
  output logic [15:0]       cycle_count
`endif
);

  import instr_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);

  seq_state_e        state_q;
  logic [ADDR_W:0]   len_q;
  logic              halt_seen_q;
  logic              tail_q;      // current word is the high half of a LOAD
  logic [15:0]       instr_q;
  logic [1:0]        step_q;
  logic [ADDR_W:0]   pc_q;
  logic              running_q;
  logic              done_q;

  logic [15:0]       rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        need_cycles;
  logic              word_last;
  logic              is_load_head;
  logic [ADDR_W:0]   pc_next;
  logic              at_end;
  logic              halt_now;
  logic [ADDR_W:0]   start_len;
  logic              ram_we;

  // A LOAD tail is always one cycle; its bits are data, not an opcode.
  assign need_cycles  = tail_q ? 2'd1 : cycles_for(instr_q[15:12]);
  assign word_last    = (step_q + 2'd1) >= need_cycles;
  assign is_load_head = !tail_q && (instr_q[15:12] == OP_LOAD);
  assign pc_next      = pc_q + (ADDR_W+1)'(1'b1);
  assign at_end       = (pc_next == len_q);
  assign halt_now     = halt_seen_q || halt_req;
  assign start_len    = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign rd_addr      = (state_q == ST_ISSUE) ? pc_next[ADDR_W-1:0] : {ADDR_W{1'b0}};
  assign ram_we       = prog_we && (state_q != ST_ISSUE);

  prog_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_wdata),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= {(ADDR_W+1){1'b0}};
      halt_seen_q <= 1'b0;
      tail_q      <= 1'b0;
      instr_q     <= NOP_WORD;
      step_q      <= 2'd0;
      pc_q        <= {(ADDR_W+1){1'b0}};
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q       <= start_len;
            halt_seen_q <= halt_req;
            tail_q      <= 1'b0;
            step_q      <= 2'd0;
            pc_q        <= {(ADDR_W+1){1'b0}};
            if (start_len == {(ADDR_W+1){1'b0}}) begin
              state_q   <= ST_DONE;
              instr_q   <= NOP_WORD;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q   <= ST_ISSUE;
              instr_q   <= rd_data;
              running_q <= 1'b1;
              done_q    <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          halt_seen_q <= halt_seen_q || halt_req;
          if (!word_last) begin
            step_q <= step_q + 2'd1;
          end else if (is_load_head) begin
            // The high word must follow; halt cannot split the pair.
            step_q <= 2'd0;
            tail_q <= 1'b1;
            if (at_end) begin
              instr_q <= NOP_WORD;   // pad the truncated LOAD, pc holds
            end else begin
              pc_q    <= pc_next;
              instr_q <= rd_data;
            end
          end else if (halt_now || at_end) begin
            state_q   <= ST_DONE;
            instr_q   <= NOP_WORD;
            step_q    <= 2'd0;
            tail_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            pc_q    <= pc_next;
            instr_q <= rd_data;
            step_q  <= 2'd0;
            tail_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          instr_q   <= NOP_WORD;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign instr   = instr_q;
  assign step    = step_q;
  assign pc      = pc_q;
  assign running = running_q;
  assign done    = done_q;

`ifdef INSTR_SEQ_PERF_EN
  logic [15:0] instr_cnt_q;
  logic [15:0] cycle_cnt_q;

  // Saturating performance counters, cleared by reset and by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= 16'h0000;
      cycle_cnt_q <= 16'h0000;
    end else if (state_q != ST_ISSUE && start) begin
      instr_cnt_q <= 16'h0000;
      cycle_cnt_q <= 16'h0000;
    end else if (state_q == ST_ISSUE) begin
      if (cycle_cnt_q != 16'hFFFF) begin
        cycle_cnt_q <= cycle_cnt_q + 16'h0001;
      end
      // A LOAD pair counts once, when its tail completes.
      if (word_last && !is_load_head && instr_cnt_q != 16'hFFFF) begin
        instr_cnt_q <= instr_cnt_q + 16'h0001;
      end
    end
  end

  assign instr_count = instr_cnt_q;
  assign cycle_count = cycle_cnt_q;
`endif

endmodule
